regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the pipelined CPU. It replaces the fixed 16x16, two-read-port file. It adds a configurable number of read ports, an optional hard-wired zero register, and write-to-read bypass. It also carries a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers. It sits between decode (read and issue) and writeback (write).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of architectural registers (2..64; power of two not required)
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG0, 1, when 1, register 0 always reads 0 and is never written or marked busy
- BYPASS, 1, when 1, a same-cycle writeback is forwarded to matching read ports

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p is at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, one DATA_W slice per port
- rd_busy  out  NUM_RD  per-port busy flag of the addressed register
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- iss_en  in  1  an instruction with a destination register issues this cycle
- iss_addr  in  ADDR_W  destination of the issuing instruction
- flush  in  1  pipeline flush; clears all busy bits
- busy_count  out  ADDR_W+1  registered number of busy registers

## Operation
- Storage: NUM_REGS x DATA_W flops and a NUM_REGS-bit busy vector.
- Reset (asynchronous) clears all registers to 0, all busy bits to 0 and busy_count to 0.
  - rd_data then reads 0 and rd_busy reads 0 for every address.
- Write: on a clock edge with wr_en high, registers[wr_addr] <= wr_data.
  - Ignored when wr_addr >= NUM_REGS, or when ZERO_REG0 and wr_addr == 0.
- Read (combinational, per port p):
  - Returns 0 when the address is out of range, or when ZERO_REG0 and the address is 0.
  - Otherwise, when BYPASS, wr_en and wr_addr == rd_addr[p] (and the write is legal), returns wr_data.
  - Otherwise returns the stored value.
- Busy (combinational, per port p):
  - rd_busy[p] = busy[rd_addr[p]], and 0 when the address is out of range.
  - When BYPASS and a legal writeback matches the address this cycle, rd_busy[p] = 0. The exception is a same-cycle iss_en to that same address, in which case rd_busy[p] = 1.
- Scoreboard update per clock edge, applied in this order:
  1. flush: clear all busy bits.
  2. Writeback: a legal wr_en clears busy[wr_addr].
  3. Issue: a legal iss_en sets busy[iss_addr]. Issue wins over writeback and flush for the same register.
- Illegal issues are ignored: iss_addr out of range, or ZERO_REG0 and iss_addr == 0.
- busy_count is the popcount of the next busy vector, registered on the same edge.
- A writeback to a register that is not busy is legal. The data is written and the busy bit is unchanged.

## Timing
- Read latency 0: rd_data and rd_busy are combinational from rd_addr, the stored state and the bypass inputs.
- Write-to-read latency is 1 cycle via storage, or 0 cycles when BYPASS.
- Issue-to-busy latency is 1 cycle. busy_count reflects the state of the same edge.
- Reset asserted mid-operation discards all stored data and pending busy bits immediately, without waiting for a clock edge. A write on the edge where reset deasserts is ignored if reset is still high at that edge.
- No combinational path from iss_en or flush to rd_data. iss_en reaches rd_busy only through the same-cycle rule above.

## Structure
- Package regfile_pkg holds the default constants (DATA_W, NUM_REGS, NUM_RD) and a function that checks whether an address is legal (in range and not the zero register).
- Sub-module regfile_scoreboard holds the busy vector, the flush/writeback/issue priority logic and the popcount for busy_count.
- The top level holds the storage, the read multiplexers and the bypass logic.

## Test plan
- Reset then read: assert reset, read all 16 addresses on both ports -> rd_data=0x0000, rd_busy=0, busy_count=0.
- Zero register: write 0xBEEF to r0, issue r0 -> reads of r0 return 0x0000, rd_busy=0, busy_count=0. A write of 0xBEEF to r5 reads 0xBEEF next cycle.
- Bypass: with r3=0x1111, write 0x2222 to r3 while both ports read r3 in the same cycle -> both return 0x2222. With BYPASS=0 they return 0x1111 that cycle and 0x2222 the next.
- Scoreboard: issue r4 -> next cycle rd_busy=1, busy_count=1. Writeback r4=0x00A5 and issue r4 in the same cycle -> r4 stays busy, data is 0x00A5. Writeback r4 alone -> busy cleared, busy_count=0.
- Flush: issue r1, r2, r7 on successive cycles -> busy_count=3. Assert flush together with issue r9 -> busy_count=1, and only r9 is busy.
- Asynchronous reset mid-run: with r6=0x7777 and r6 busy, pulse reset between clock edges -> r6 reads 0x0000 and rd_busy=0 before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address-legality helper for the register file and its scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_NUM_RD   = 2;

  // A register address is usable when it exists and is not the hard-wired zero register.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned num_regs,
                                      input bit          zero_reg0);
    return (addr < num_regs) && !(zero_reg0 && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file: read ports, writeback, issue and flush.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEFAULT_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector with flush < writeback < issue priority and a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_legal,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                iss_legal,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_count
);

  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count_next;

  // Later statements override earlier ones, so issue beats writeback beats flush.
  always_comb begin
    busy_next = busy;
    if (flush)
      busy_next = '0;
    if (wr_legal)
      busy_next[wr_addr] = 1'b0;
    if (iss_legal)
      busy_next[iss_addr] = 1'b1;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with optional zero register, write-to-read bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int NUM_RD    = DEFAULT_NUM_RD,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_legal;
  logic                iss_legal;
  logic [DATA_W-1:0]   rd_val [NUM_RD];
  logic                rd_bsy [NUM_RD];

  assign wr_legal  = bus.wr_en  && addr_legal(32'(bus.wr_addr),  NUM_REGS, ZERO_REG0 != 0);
  assign iss_legal = bus.iss_en && addr_legal(32'(bus.iss_addr), NUM_REGS, ZERO_REG0 != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_legal) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .wr_legal   (wr_legal),
    .wr_addr    (bus.wr_addr),
    .iss_legal  (iss_legal),
    .iss_addr   (bus.iss_addr),
    .busy       (busy),
    .busy_count (bus.busy_count)
  );

  // A bypassed writeback retires the producer, so the port sees not-busy unless a new
  // producer for the same register issues in this very cycle.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic              readable;
    logic              wr_hit;
    logic              iss_hit;

    assign addr     = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign in_range = 32'(addr) < 32'(NUM_REGS);
    assign readable = addr_legal(32'(addr), NUM_REGS, ZERO_REG0 != 0);
    assign wr_hit   = (BYPASS != 0) && wr_legal && (bus.wr_addr == addr);
    assign iss_hit  = iss_legal && (bus.iss_addr == addr);

    assign rd_val[p] = !readable ? '0 : (wr_hit ? bus.wr_data : regs[addr]);
    assign rd_bsy[p] = !in_range ? 1'b0 : (wr_hit ? iss_hit : busy[addr]);
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = rd_val[p];
      bus.rd_busy[p]                  = rd_bsy[p];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: directed vector table, async-reset sequence and randomized run vs a reference model.
module tb_regfile_sb;

  localparam int DW  = 16;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) bus ();
  regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) bus_nb ();

  assign bus_nb.rd_addr  = bus.rd_addr;
  assign bus_nb.wr_en    = bus.wr_en;
  assign bus_nb.wr_addr  = bus.wr_addr;
  assign bus_nb.wr_data  = bus.wr_data;
  assign bus_nb.iss_en   = bus.iss_en;
  assign bus_nb.iss_addr = bus.iss_addr;
  assign bus_nb.flush    = bus.flush;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG0(1), .BYPASS(1))
    dut (.clk(clk), .reset(reset), .bus(bus));

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG0(1), .BYPASS(0))
    dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  typedef struct {
    int rd0, rd1;
    int wr_en, wr_addr, wr_data;
    int iss_en, iss_addr, flush;
    int d0, d1, nd0, b0, b1, cnt;
  } vec_t;

  vec_t vecs [15];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: architectural contents and busy flags as the specification describes them.
  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];
  int            m_count;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_count = 0;
  endtask

  task automatic model_edge();
    int wa, ia;
    wa = int'(bus.wr_addr);
    ia = int'(bus.iss_addr);
    if (bus.flush)
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    if (bus.wr_en && wa != 0) begin
      m_mem[wa]  = bus.wr_data;
      m_busy[wa] = 1'b0;
    end
    if (bus.iss_en && ia != 0)
      m_busy[ia] = 1'b1;
    m_count = 0;
    for (int i = 0; i < NR; i++) m_count += int'(m_busy[i]);
  endtask

  function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    if (a != 0 && byp && bus.wr_en && int'(bus.wr_addr) == a)
      return bus.iss_en && int'(bus.iss_addr) == a;
    return m_busy[a];
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.rd_addr  = {AW'(v.rd1), AW'(v.rd0)};
    bus.wr_en    = v.wr_en != 0;
    bus.wr_addr  = AW'(v.wr_addr);
    bus.wr_data  = DW'(v.wr_data);
    bus.iss_en   = v.iss_en != 0;
    bus.iss_addr = AW'(v.iss_addr);
    bus.flush    = v.flush != 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic checkModel(input string tag);
    int a;
    for (int p = 0; p < NRD; p++) begin
      a = int'(bus.rd_addr[p*AW +: AW]);
      checkOutput($sformatf("%s data p%0d", tag, p),    32'(bus.rd_data[p*DW +: DW]),    32'(exp_data(a, 1'b1)));
      checkOutput($sformatf("%s busy p%0d", tag, p),    32'(bus.rd_busy[p]),             32'(exp_busy(a, 1'b1)));
      checkOutput($sformatf("%s nb data p%0d", tag, p), 32'(bus_nb.rd_data[p*DW +: DW]), 32'(exp_data(a, 1'b0)));
      checkOutput($sformatf("%s nb busy p%0d", tag, p), 32'(bus_nb.rd_busy[p]),          32'(exp_busy(a, 1'b0)));
    end
  endtask

  initial begin
    vec_t v;
    //           rd0 rd1 we wa wdata    ie ia fl  d0       d1       nd0      b0 b1 cnt
    vecs[0]  = '{0,  5,  1, 0, 'hBEEF, 1, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0};
    vecs[1]  = '{0,  0,  1, 5, 'hBEEF, 0, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0};
    vecs[2]  = '{5,  0,  0, 0, 'h0000, 0, 0, 0, 'hBEEF, 'h0000, 'hBEEF, 0, 0, 0};
    vecs[3]  = '{0,  0,  1, 3, 'h1111, 0, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0};
    vecs[4]  = '{3,  3,  1, 3, 'h2222, 0, 0, 0, 'h2222, 'h2222, 'h1111, 0, 0, 0};
    vecs[5]  = '{3,  4,  0, 0, 'h0000, 1, 4, 0, 'h2222, 'h0000, 'h2222, 0, 0, 1};
    vecs[6]  = '{4,  4,  1, 4, 'h00A5, 1, 4, 0, 'h00A5, 'h00A5, 'h0000, 1, 1, 1};
    vecs[7]  = '{4,  3,  0, 0, 'h0000, 0, 0, 0, 'h00A5, 'h2222, 'h00A5, 1, 0, 1};
    vecs[8]  = '{4,  4,  1, 4, 'h00A5, 0, 0, 0, 'h00A5, 'h00A5, 'h00A5, 0, 0, 0};
    vecs[9]  = '{1,  2,  0, 0, 'h0000, 1, 1, 0, 'h0000, 'h0000, 'h0000, 0, 0, 1};
    vecs[10] = '{1,  2,  0, 0, 'h0000, 1, 2, 0, 'h0000, 'h0000, 'h0000, 1, 0, 2};
    vecs[11] = '{1,  7,  0, 0, 'h0000, 1, 7, 0, 'h0000, 'h0000, 'h0000, 1, 0, 3};
    vecs[12] = '{7,  9,  0, 0, 'h0000, 1, 9, 1, 'h0000, 'h0000, 'h0000, 1, 0, 1};
    vecs[13] = '{1,  9,  0, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 'h0000, 0, 1, 1};
    vecs[14] = '{9,  2,  1, 9, 'h1234, 0, 0, 0, 'h1234, 'h0000, 'h0000, 0, 0, 0};

    reset = 1'b1;
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(v);
    model_reset();
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    for (int a = 0; a < NR; a++) begin
      bus.rd_addr = {AW'(a), AW'(a)};
      #1;
      checkOutput($sformatf("reset data r%0d p0", a), 32'(bus.rd_data[DW-1:0]),  32'h0);
      checkOutput($sformatf("reset data r%0d p1", a), 32'(bus.rd_data[2*DW-1:DW]), 32'h0);
      checkOutput($sformatf("reset busy r%0d", a),    32'(bus.rd_busy),          32'h0);
    end
    checkOutput("reset busy_count", 32'(bus.busy_count), 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d d0", i),  32'(bus.rd_data[DW-1:0]),    32'(vecs[i].d0));
      checkOutput($sformatf("vec%0d d1", i),  32'(bus.rd_data[2*DW-1:DW]), 32'(vecs[i].d1));
      checkOutput($sformatf("vec%0d nd0", i), 32'(bus_nb.rd_data[DW-1:0]), 32'(vecs[i].nd0));
      checkOutput($sformatf("vec%0d b0", i),  32'(bus.rd_busy[0]),         32'(vecs[i].b0));
      checkOutput($sformatf("vec%0d b1", i),  32'(bus.rd_busy[1]),         32'(vecs[i].b1));
      tick();
      checkOutput($sformatf("vec%0d cnt", i), 32'(bus.busy_count),         32'(vecs[i].cnt));
    end

    $display("[TB] asynchronous reset between edges");
    v = '{6, 6, 1, 6, 'h7777, 1, 6, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(v);
    tick();
    v = '{6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(v);
    #1;
    checkOutput("pre-reset r6 data", 32'(bus.rd_data[DW-1:0]), 32'h7777);
    checkOutput("pre-reset r6 busy", 32'(bus.rd_busy[0]),      32'h1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("async reset r6 data",    32'(bus.rd_data[DW-1:0]),    32'h0);
    checkOutput("async reset r6 busy",    32'(bus.rd_busy[0]),         32'h0);
    checkOutput("async reset busy_count", 32'(bus.busy_count),         32'h0);
    checkOutput("async reset nb data",    32'(bus_nb.rd_data[DW-1:0]), 32'h0);
    tick();

    $display("[TB] randomized run");
    for (int c = 0; c < 400; c++) begin
      bus.wr_en    = $urandom_range(1) == 1;
      bus.wr_addr  = AW'($urandom_range(NR - 1));
      bus.wr_data  = DW'($urandom);
      bus.iss_en   = $urandom_range(1) == 1;
      bus.iss_addr = ($urandom_range(3) == 0) ? bus.wr_addr : AW'($urandom_range(NR - 1));
      bus.flush    = $urandom_range(15) == 0;
      bus.rd_addr  = {AW'($urandom_range(NR - 1)),
                      ($urandom_range(3) == 0) ? bus.wr_addr : AW'($urandom_range(NR - 1))};
      #1;
      checkModel($sformatf("rand%0d", c));
      tick();
      checkOutput($sformatf("rand%0d busy_count", c),    32'(bus.busy_count),    32'(m_count));
      checkOutput($sformatf("rand%0d nb busy_count", c), 32'(bus_nb.busy_count), 32'(m_count));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
